// File: rtl/kersram_r_if.sv
// Bus bundle between the kernel SRAM read engine, the SRAM banks and the PE array.
// The master side starts bursts and consumes weights; the slave side is the read engine.
interface kersram_r_if #(
  parameter int KER_AW = 11,
  parameter int KER_DW = 64,
  parameter int KER_NB = 8
) ();
  logic                     start_ker_read;
  logic [KER_AW-1:0]        ker_read_base;
  logic [KER_AW:0]          ker_read_len;
  logic                     ker_read_busy;
  logic                     ker_read_done;
  logic [KER_NB-1:0]        cen_kersr;
  logic [KER_NB-1:0]        wen_kersr;
  logic [KER_AW-1:0]        addr__kersr;
  logic [KER_NB*KER_DW-1:0] dout_kersr;
  logic [KER_NB*KER_DW-1:0] ker_data_dout;
  logic                     ker_data_valid;
  logic                     ker_data_ready;

  modport master (
    output start_ker_read, ker_read_base, ker_read_len, dout_kersr, ker_data_ready,
    input  ker_read_busy, ker_read_done, cen_kersr, wen_kersr, addr__kersr,
           ker_data_dout, ker_data_valid
  );

  modport slave (
    input  start_ker_read, ker_read_base, ker_read_len, dout_kersr, ker_data_ready,
    output ker_read_busy, ker_read_done, cen_kersr, wen_kersr, addr__kersr,
           ker_data_dout, ker_data_valid
  );
endinterface

// File: rtl/kersram_r.sv
// Kernel SRAM burst reader: issues lockstep reads across all banks and streams the
// returned words through a 2-entry FIFO to the PE array with valid/ready flow control.
module kersram_r #(
  parameter int KER_AW = 11,
  parameter int KER_DW = 64,
  parameter int KER_NB = 8
) (
  input  logic clk,
  input  logic reset,
  kersram_r_if.slave bus
);
  localparam int W = KER_NB * KER_DW;
  localparam logic [KER_AW-1:0] ADDR_ONE = 1;
  localparam logic [KER_AW:0]   REM_ONE  = 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state;
  logic [KER_AW-1:0] cur_addr;
  logic [KER_AW-1:0] addr_hold;
  logic [KER_AW:0]   remaining;
  logic              inflight;
  logic [1:0]        fifo_count;
  logic              rd_ptr;
  logic              wr_ptr;
  logic [W-1:0]      fifo_mem [2];
  logic              done_zero;

  logic       pop;
  logic       issue;
  logic       drain_done;
  logic [2:0] occupancy;

  // Count a word popped this cycle as already gone so full throughput survives ready=1.
  assign pop        = (fifo_count != 2'd0) && bus.ker_data_ready;
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == READ) && (remaining != '0) && (occupancy < 3'd2);
  assign drain_done = (state == DRAIN) && !inflight && (fifo_count == {1'b0, pop});

  assign bus.cen_kersr      = issue ? '0 : '1;
  assign bus.wen_kersr      = '1;
  assign bus.addr__kersr    = issue ? cur_addr : addr_hold;
  assign bus.ker_data_valid = (fifo_count != 2'd0);
  assign bus.ker_data_dout  = fifo_mem[rd_ptr];
  assign bus.ker_read_done  = done_zero | drain_done;
  assign bus.ker_read_busy  = (state != IDLE) | done_zero;

  // Zero-length bursts never leave IDLE; done_zero supplies their single busy/done cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_addr   <= '0;
      addr_hold  <= '0;
      remaining  <= '0;
      inflight   <= 1'b0;
      fifo_count <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      done_zero  <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      done_zero  <= 1'b0;
      inflight   <= issue;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
      if (inflight) begin
        fifo_mem[wr_ptr] <= bus.dout_kersr;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (issue) begin
        cur_addr  <= cur_addr + ADDR_ONE;
        addr_hold <= cur_addr;
        remaining <= remaining - REM_ONE;
      end
      case (state)
        IDLE: begin
          if (bus.start_ker_read) begin
            cur_addr  <= bus.ker_read_base;
            remaining <= bus.ker_read_len;
            if (bus.ker_read_len == '0) done_zero <= 1'b1;
            else                        state     <= READ;
          end
        end
        READ: begin
          if (issue && (remaining == REM_ONE)) state <= DRAIN;
        end
        DRAIN: begin
          if (drain_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kersram_r.sv
// Randomized bench for kersram_r: an SRAM bank model plus a queue-based reference of
// expected addresses and weight words, checked cycle by cycle.
module tb_kersram_r;
  localparam int AW = 11;
  localparam int DW = 64;
  localparam int NB = 8;
  localparam int W  = NB * DW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] salt = 32'h1234_5678;
  int   issue_cyc[$];
  int   pop_cyc[$];
  int   done_cyc;

  always #5 clk = ~clk;

  kersram_r_if #(.KER_AW(AW), .KER_DW(DW), .KER_NB(NB)) bus ();

  kersram_r #(.KER_AW(AW), .KER_DW(DW), .KER_NB(NB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Each bank returns a word derived from address, bank index and the current salt.
  function automatic logic [W-1:0] ref_word(input int unsigned a, input logic [31:0] s);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < NB; i++)
      w[i*DW +: DW] = {s ^ (32'(i) << 24), (32'(a) * 32'h9E37_79B1) + 32'(i)};
    return w;
  endfunction

  always @(posedge clk)
    if (bus.cen_kersr == '0) bus.dout_kersr <= ref_word(32'(bus.addr__kersr), salt);

  task automatic check_reset_outputs(input string tag);
    vectors++; if (bus.cen_kersr !== '1) begin miscompares++; $display("[TB] FAIL %s_cen: got %h expected %h", tag, bus.cen_kersr, {NB{1'b1}}); end
    vectors++; if (bus.wen_kersr !== '1) begin miscompares++; $display("[TB] FAIL %s_wen: got %h expected %h", tag, bus.wen_kersr, {NB{1'b1}}); end
    vectors++; if (bus.addr__kersr !== '0) begin miscompares++; $display("[TB] FAIL %s_addr: got %h expected 0", tag, bus.addr__kersr); end
    vectors++; if (bus.ker_data_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_valid: got %b expected 0", tag, bus.ker_data_valid); end
    vectors++; if (bus.ker_data_dout !== '0) begin miscompares++; $display("[TB] FAIL %s_dout: got %h expected 0", tag, bus.ker_data_dout); end
    vectors++; if (bus.ker_read_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_busy: got %b expected 0", tag, bus.ker_read_busy); end
    vectors++; if (bus.ker_read_done !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_done: got %b expected 0", tag, bus.ker_read_done); end
  endtask

  // Runs one burst from cycle 0 (start asserted) until done, checking every cycle.
  task automatic run_burst(input int base, input int len, input int ready_pct,
                           input int ready_low, input int inject_at, input int max_cyc);
    logic [AW-1:0] exp_addr[$];
    logic [W-1:0]  exp_data[$];
    logic [W-1:0]  prev_dout;
    int   issued, popped;
    bit   done_seen, prev_hold, rdy;
    issued = 0; popped = 0; done_seen = 0; prev_hold = 0; prev_dout = '0;
    for (int k = 0; k < len; k++) begin
      int unsigned a;
      a = (base + k) % (1 << AW);
      exp_addr.push_back(a[AW-1:0]);
      exp_data.push_back(ref_word(a, salt));
    end
    issue_cyc.delete(); pop_cyc.delete(); done_cyc = -1;

    @(negedge clk);
    bus.start_ker_read = 1'b1;
    bus.ker_read_base  = AW'(base);
    bus.ker_read_len   = (AW+1)'(len);
    bus.ker_data_ready = (ready_low > 0) ? 1'b0 : ($urandom_range(99) < ready_pct);
    #1;
    vectors++; if (bus.ker_read_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_at_start: got %b expected 0", bus.ker_read_busy); end
    vectors++; if (bus.cen_kersr !== '1) begin miscompares++; $display("[TB] FAIL cen_at_start: got %h expected %h", bus.cen_kersr, {NB{1'b1}}); end

    for (int cyc = 1; cyc <= max_cyc && !done_seen; cyc++) begin
      @(negedge clk);
      bus.start_ker_read = (cyc == inject_at);
      if (cyc == inject_at) begin
        bus.ker_read_base = AW'($urandom);
        bus.ker_read_len  = (AW+1)'($urandom_range(40, 1));
      end
      rdy = (cyc < ready_low) ? 1'b0 : ($urandom_range(99) < ready_pct);
      bus.ker_data_ready = rdy;
      #1;
      if (prev_hold) begin
        vectors++;
        if (bus.ker_data_valid !== 1'b1 || bus.ker_data_dout !== prev_dout) begin
          miscompares++; $display("[TB] FAIL hold_stable cyc %0d: got valid %b dout %h expected valid 1 dout %h", cyc, bus.ker_data_valid, bus.ker_data_dout, prev_dout);
        end
      end
      if (bus.cen_kersr !== '1) begin
        vectors++; if (bus.cen_kersr !== '0) begin miscompares++; $display("[TB] FAIL cen_lockstep cyc %0d: got %h expected 0", cyc, bus.cen_kersr); end
        vectors++;
        if (exp_addr.size() == 0) begin
          miscompares++; $display("[TB] FAIL extra_read cyc %0d: got addr %0d expected no read", cyc, bus.addr__kersr);
        end else begin
          if (bus.addr__kersr !== exp_addr[0]) begin miscompares++; $display("[TB] FAIL read_addr cyc %0d: got %0d expected %0d", cyc, bus.addr__kersr, exp_addr[0]); end
          void'(exp_addr.pop_front());
        end
        issued++; issue_cyc.push_back(cyc);
      end
      if (bus.ker_data_valid === 1'b1 && rdy) begin
        vectors++;
        if (exp_data.size() == 0) begin
          miscompares++; $display("[TB] FAIL extra_word cyc %0d: got %h expected no word", cyc, bus.ker_data_dout);
        end else begin
          if (bus.ker_data_dout !== exp_data[0]) begin miscompares++; $display("[TB] FAIL word_data cyc %0d: got %h expected %h", cyc, bus.ker_data_dout, exp_data[0]); end
          void'(exp_data.pop_front());
        end
        popped++; pop_cyc.push_back(cyc);
      end
      vectors++; if (issued - popped > 2) begin miscompares++; $display("[TB] FAIL outstanding cyc %0d: got %0d expected <= 2", cyc, issued - popped); end
      vectors++; if (bus.ker_read_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy cyc %0d: got %b expected 1", cyc, bus.ker_read_busy); end
      if (bus.ker_read_done === 1'b1) begin
        done_seen = 1; done_cyc = cyc;
        vectors++;
        if (exp_data.size() != 0 || exp_addr.size() != 0) begin
          miscompares++; $display("[TB] FAIL done_early cyc %0d: got %0d words left expected 0", cyc, exp_data.size());
        end
      end
      prev_hold = (bus.ker_data_valid === 1'b1) && !rdy;
      prev_dout = bus.ker_data_dout;
    end
    if (!done_seen) begin
      vectors++; miscompares++;
      $display("[TB] FAIL done_timeout: got no done in %0d cycles expected done", max_cyc);
    end
    @(negedge clk);
    bus.start_ker_read = 1'b0;
    bus.ker_data_ready = 1'b1;
    #1;
    vectors++;
    if (bus.ker_read_busy !== 1'b0 || bus.ker_read_done !== 1'b0 || bus.ker_data_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL post_idle: got busy %b done %b valid %b expected 0 0 0", bus.ker_read_busy, bus.ker_read_done, bus.ker_data_valid);
    end
  endtask

  task automatic test_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_timing();
    run_burst(0, 4, 100, 0, -1, 40);
    vectors++; if (issue_cyc.size() != 4) begin miscompares++; $display("[TB] FAIL basic_issue_count: got %0d expected 4", issue_cyc.size()); end
    for (int k = 0; k < issue_cyc.size() && k < 4; k++) begin
      vectors++; if (issue_cyc[k] != k + 1) begin miscompares++; $display("[TB] FAIL basic_issue_cyc%0d: got %0d expected %0d", k, issue_cyc[k], k + 1); end
    end
    for (int k = 0; k < pop_cyc.size() && k < 4; k++) begin
      vectors++; if (pop_cyc[k] != k + 3) begin miscompares++; $display("[TB] FAIL basic_valid_cyc%0d: got %0d expected %0d", k, pop_cyc[k], k + 3); end
    end
    vectors++; if (done_cyc != 6) begin miscompares++; $display("[TB] FAIL basic_done_cyc: got %0d expected 6", done_cyc); end
  endtask

  task automatic test_throughput();
    salt = $urandom;
    run_burst(100, 12, 100, 0, -1, 60);
    vectors++; if (pop_cyc.size() != 12) begin miscompares++; $display("[TB] FAIL tput_words: got %0d expected 12", pop_cyc.size()); end
    for (int k = 1; k < pop_cyc.size(); k++) begin
      vectors++; if (pop_cyc[k] != pop_cyc[k-1] + 1) begin miscompares++; $display("[TB] FAIL tput_gap%0d: got %0d expected %0d", k, pop_cyc[k], pop_cyc[k-1] + 1); end
    end
    vectors++; if (done_cyc != 14) begin miscompares++; $display("[TB] FAIL tput_done_cyc: got %0d expected 14", done_cyc); end
  endtask

  task automatic test_backpressure();
    int early;
    salt = $urandom;
    run_burst(5, 6, 100, 10, -1, 80);
    early = 0;
    foreach (issue_cyc[k]) if (issue_cyc[k] < 10) early++;
    vectors++; if (early < 1 || early > 2) begin miscompares++; $display("[TB] FAIL bp_reads_while_stalled: got %0d expected 1..2", early); end
    vectors++; if (pop_cyc.size() == 0 || pop_cyc[0] != 10) begin miscompares++; $display("[TB] FAIL bp_first_pop: got %0d expected 10", pop_cyc.size() ? pop_cyc[0] : -1); end
  endtask

  task automatic test_zero_len();
    run_burst(77, 0, 100, 0, -1, 20);
    vectors++; if (done_cyc != 1) begin miscompares++; $display("[TB] FAIL zero_done_cyc: got %0d expected 1", done_cyc); end
    vectors++; if (issue_cyc.size() != 0 || pop_cyc.size() != 0) begin miscompares++; $display("[TB] FAIL zero_activity: got %0d reads %0d words expected 0 0", issue_cyc.size(), pop_cyc.size()); end
  endtask

  task automatic test_wrap();
    salt = $urandom;
    run_burst(2046, 3, 100, 0, -1, 40);
    vectors++; if (issue_cyc.size() != 3) begin miscompares++; $display("[TB] FAIL wrap_reads: got %0d expected 3", issue_cyc.size()); end
  endtask

  task automatic test_start_ignored();
    salt = $urandom;
    run_burst(300, 6, 100, 0, 2, 60);
    vectors++; if (done_cyc != 8) begin miscompares++; $display("[TB] FAIL ignore_done_cyc: got %0d expected 8", done_cyc); end
  endtask

  task automatic test_reset_mid();
    int popped;
    bit hit;
    popped = 0; hit = 0;
    @(negedge clk);
    bus.start_ker_read = 1'b1;
    bus.ker_read_base  = AW'($urandom);
    bus.ker_read_len   = 12'd8;
    bus.ker_data_ready = 1'b1;
    for (int cyc = 1; cyc <= 30 && !hit; cyc++) begin
      @(negedge clk);
      bus.start_ker_read = 1'b0;
      #1;
      if (bus.ker_data_valid === 1'b1) popped++;
      if (popped == 2) hit = 1;
    end
    if (!hit) begin
      vectors++; miscompares++; $display("[TB] FAIL midreset_timeout: got %0d words expected 2", popped);
    end
    #1 reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    salt = $urandom;
    run_burst(int'($urandom_range(2047)), 5, 100, 0, -1, 40);
    vectors++; if (done_cyc != 7) begin miscompares++; $display("[TB] FAIL after_reset_done_cyc: got %0d expected 7", done_cyc); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      int len;
      salt = $urandom;
      len = $urandom_range(20);
      run_burst(int'($urandom_range(2047)), len, $urandom_range(100, 30), $urandom_range(4), -1, 60 + len * 40);
    end
  endtask

  initial begin
    bus.start_ker_read = 1'b0;
    bus.ker_read_base  = '0;
    bus.ker_read_len   = '0;
    bus.ker_data_ready = 1'b0;
    $display("[TB] kersram_r bench starting");
    test_reset();
    test_basic_timing();
    test_throughput();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/kersram_r.md
KERSRAM_R -- requirements
Module: kersram_r

Interface
REQ-001 Parameter KER_AW, 11, kernel SRAM address width.
REQ-002 Parameter KER_DW, 64, data width of one kernel SRAM bank.
REQ-003 Parameter KER_NB, 8, number of kernel SRAM banks read in lockstep.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port clk  in  1  clock; all state updates on rising edge.
REQ-006 Port reset  in  1  asynchronous active-high reset.
REQ-007 Port start_ker_read  in  1  one-cycle request to begin a burst.
REQ-008 Port ker_read_base  in  KER_AW  first SRAM address of the burst, sampled at start.
REQ-009 Port ker_read_len  in  KER_AW+1  number of words in the burst, sampled at start.
REQ-010 Port ker_read_busy  out  1  burst in progress.
REQ-011 Port ker_read_done  out  1  one-cycle completion pulse.
REQ-012 Port cen_kersr  out  KER_NB  per-bank chip enable, active-low.
REQ-013 Port wen_kersr  out  KER_NB  per-bank write enable, active-low; held 1 (read-only).
REQ-014 Port addr__kersr  out  KER_AW  address shared by all banks.
REQ-015 Port dout_kersr  in  KER_NB*KER_DW  bank data; bank i occupies bits [i*KER_DW +: KER_DW]; valid the cycle after a read is issued.
REQ-016 Port ker_data_dout  out  KER_NB*KER_DW  weight word to the PE array, same bank ordering.
REQ-017 Port ker_data_valid  out  1  ker_data_dout holds a valid word.
REQ-018 Port ker_data_ready  in  1  consumer accepts the word when valid and ready are both 1.

Function
REQ-019 The FSM SHALL have states IDLE, READ, DRAIN: IDLE->READ on start_ker_read; READ->DRAIN when the last address is issued; DRAIN->IDLE when nothing is in flight and the FIFO is empty.
REQ-020 start_ker_read SHALL be accepted only in IDLE; asserting it in READ or DRAIN SHALL have no effect.
REQ-021 A read SHALL be issued in a READ cycle iff remaining>0 and (fifo_count + inflight - pop) < 2, where pop = valid&ready in that cycle.
REQ-022 Issuing a read SHALL drive cen_kersr=all 0 and addr__kersr=current address; otherwise cen_kersr=all 1 and addr__kersr holds its last value.
REQ-023 The address SHALL start at ker_read_base, increment by 1 per issued read, and wrap from 2^KER_AW-1 to 0.
REQ-024 Data for a read issued in cycle N SHALL be captured from dout_kersr at the end of cycle N+1 into a 2-entry FIFO; ker_data_valid SHALL be 1 from cycle N+2 onward until popped.
REQ-025 ker_data_valid SHALL equal FIFO non-empty; ker_data_dout SHALL equal the FIFO head and stay stable while valid=1 and ready=0.
REQ-026 Words SHALL leave in address order with no loss or duplication; the FIFO SHALL never overflow under any ready pattern.
REQ-027 With ready held 1, one word per cycle SHALL be sustained after the first word.
REQ-028 ker_read_len=0 SHALL skip READ/DRAIN, issue no reads, and pulse ker_read_done in the cycle after acceptance.
REQ-029 ker_read_busy SHALL be 1 from the cycle after acceptance through the ker_read_done cycle inclusive.
REQ-030 ker_read_done SHALL pulse for exactly one cycle, in the cycle the FSM returns to IDLE.
REQ-031 A pop and a capture in the same cycle SHALL both take effect; fifo_count is unchanged.

Reset
REQ-032 On reset: state=IDLE, cen_kersr=all 1, wen_kersr=all 1, addr__kersr=0, FIFO empty, ker_data_valid=0, ker_data_dout=0, busy=0, done=0, counters 0.
REQ-033 Reset asserted mid-burst SHALL take effect immediately, abandon the burst, and discard in-flight data.

Verification
REQ-034 base=0, len=4, ready=1, start in cycle T -> cen low in T+1..T+4 with addr 0,1,2,3; valid T+3..T+6 carrying bank data of addr 0..3; done at T+6.
REQ-035 base=5, len=6, ready=0 -> at most 2 reads issued, valid held with addr-5 data stable; ready=1 -> addr 5..10 delivered in order.
REQ-036 len=0 -> no cen assertion, valid never 1, done pulses at T+1.
REQ-037 base=2046, len=3 -> addresses 2046, 2047, 0 issued in order.
REQ-038 Reset asserted after the 2nd word of an 8-word burst -> all outputs at reset values immediately; a new start then runs normally.
REQ-039 start pulsed during READ -> ignored; burst completes with its original base/len and a single done pulse.
